// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the 4-way priority arbiter
//
// Purpose: FSM state encoding, arbitration mode constants and an index to
// one-hot helper used by the arbiter top and its testbench.
// Ports: none (package).

package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  function automatic logic [3:0] id_to_onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/prio_arbiter4_if.sv
// rtl/prio_arbiter4_if.sv - request/grant bundle between agents and the arbiter
//
// Purpose: groups the request/grant handshake of the 4-way arbiter.
// Signals:
//   req       4  level request per requester
//   gnt       4  one-hot grant
//   gnt_id    2  encoded grantee index (valid when gnt_valid)
//   gnt_valid 1  any grant active
//   preempt   1  pulse in the gap cycle after a timeout preemption
// Modports: master = requesting side, slave = arbiter side.

interface prio_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output preempt
  );
endinterface

// File: rtl/prio_enc4_rot.sv
// rtl/prio_enc4_rot.sv - combinational rotated 4-input priority encoder
//
// Purpose: picks the first set bit of (req & ~mask), scanning from index
// base downward with wrap-around (base, base-1, base-2, base-3 mod 4).
// Ports:
//   req   in  4  request vector
//   base  in  2  index with highest priority
//   mask  in  4  requesters excluded from selection
//   any   out 1  some unmasked request is set
//   idx   out 2  winning index (0 when any=0)

module prio_enc4_rot (
  input  logic [3:0] req,
  input  logic [1:0] base,
  input  logic [3:0] mask,
  output logic       any,
  output logic [1:0] idx
);

  logic [3:0] cand;
  logic [1:0] pos;

  always_comb begin
    any  = 1'b0;
    idx  = 2'd0;
    pos  = 2'd0;
    cand = req & ~mask;
    // Walk from lowest to highest priority so the highest-priority hit is
    // the last one written.
    for (int k = 3; k >= 0; k--) begin
      pos = base - 2'(k);
      if (cand[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter4.sv
// rtl/prio_arbiter4.sv - sequential 4-way arbiter with optional round-robin and hold timer
//
// Purpose: grants one shared resource to one of four requesters. Grants are
// held while the owner's request stays high, and every change of owner goes
// through a single gap cycle with no grant. With MAX_HOLD>0 an owner is
// preempted after MAX_HOLD grant cycles if another requester is waiting.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous active-low reset
//   bus    slave modport of prio_arbiter4_if (req in; gnt, gnt_id,
//          gnt_valid, preempt out, all registered)

module prio_arbiter4
  import arb_pkg::*;
#(
  parameter int RR_MODE  = RR_FIXED,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  prio_arbiter4_if.slave    bus
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LAST_I);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

  arb_state_t       state;
  logic [3:0]       gnt_r;
  logic [1:0]       gnt_id_r;
  logic             gnt_valid_r;
  logic             preempt_r;
  logic [CNT_W-1:0] hold_cnt;
  logic [1:0]       last_id;

  logic [1:0] base;
  logic [3:0] sel_mask;
  logic       sel_any;
  logic [1:0] sel_idx;
  logic       owner_release;
  logic       others_wait;
  logic       timeout;

  // Fixed mode always starts the scan at 3; round-robin starts just below
  // the last grantee so it becomes lowest priority.
  assign base = (RR_MODE == RR_ROUND) ? (last_id - 2'd1) : 2'd3;

  // preempt_r is only ever high during the gap after a timeout, and last_id
  // still names the preempted owner at that point.
  assign sel_mask = preempt_r ? id_to_onehot(last_id) : 4'b0000;

  prio_enc4_rot u_enc (
    .req  (bus.req),
    .base (base),
    .mask (sel_mask),
    .any  (sel_any),
    .idx  (sel_idx)
  );

  assign owner_release = (bus.req[gnt_id_r] != 1'b1);
  assign others_wait   = |(bus.req & ~gnt_r);
  assign timeout       = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST) && others_wait;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_r       <= 4'b0000;
      gnt_id_r    <= 2'd0;
      gnt_valid_r <= 1'b0;
      preempt_r   <= 1'b0;
      hold_cnt    <= '0;
      last_id     <= 2'd0;
    end else begin
      preempt_r <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (sel_any) begin
            state       <= GRANT;
            gnt_r       <= id_to_onehot(sel_idx);
            gnt_id_r    <= sel_idx;
            gnt_valid_r <= 1'b1;
            last_id     <= sel_idx;
            hold_cnt    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (owner_release || timeout) begin
            state       <= GAP;
            gnt_r       <= 4'b0000;
            gnt_valid_r <= 1'b0;
            // A release on the timeout cycle wins: no preemption reported.
            preempt_r   <= !owner_release;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_id    = gnt_id_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.preempt   = preempt_r;

endmodule

// File: tb/tb_prio_arbiter4.sv
// tb/tb_prio_arbiter4.sv - self-checking bench for prio_arbiter4

module tb_prio_arbiter4;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_arbiter4_if if_fix ();
  prio_arbiter4_if if_rr ();
  prio_arbiter4_if if_ph ();

  prio_arbiter4 #(.RR_MODE(RR_FIXED), .MAX_HOLD(16)) dut_fix (.clk(clk), .rst_n(rst_n), .bus(if_fix.slave));
  prio_arbiter4 #(.RR_MODE(RR_ROUND), .MAX_HOLD(0))  dut_rr  (.clk(clk), .rst_n(rst_n), .bus(if_rr.slave));
  prio_arbiter4 #(.RR_MODE(RR_FIXED), .MAX_HOLD(4))  dut_ph  (.clk(clk), .rst_n(rst_n), .bus(if_ph.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, got, exp);
    end
  endtask

  task automatic chk_grant(input string nm, input logic [3:0] g, input logic [1:0] id,
                           input logic v, input logic p,
                           input logic [3:0] eg, input logic [1:0] eid, input logic ep);
    chk({nm, ".gnt"}, g, eg);
    chk({nm, ".valid"}, {3'b0, v}, {3'b0, |eg});
    chk({nm, ".preempt"}, {3'b0, p}, {3'b0, ep});
    if (eg != 4'b0000) chk({nm, ".gnt_id"}, {2'b0, id}, {2'b0, eid});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_fix.req = 4'b0000;
    if_rr.req  = 4'b0000;
    if_ph.req  = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] rr_order [5];
    logic [1:0] cur;

    vecs[0]  = '{4'b0110, 4'b0100, 2'd2};
    vecs[1]  = '{4'b0010, 4'b0000, 2'd0};
    vecs[2]  = '{4'b0010, 4'b0010, 2'd1};
    vecs[3]  = '{4'b1010, 4'b0010, 2'd1};
    vecs[4]  = '{4'b1000, 4'b0000, 2'd0};
    vecs[5]  = '{4'b1001, 4'b1000, 2'd3};
    vecs[6]  = '{4'b0001, 4'b0000, 2'd0};
    vecs[7]  = '{4'b0001, 4'b0001, 2'd0};
    vecs[8]  = '{4'b0000, 4'b0000, 2'd0};
    vecs[9]  = '{4'b0000, 4'b0000, 2'd0};
    vecs[10] = '{4'b1111, 4'b1000, 2'd3};

    rr_order[0] = 2'd3; rr_order[1] = 2'd2; rr_order[2] = 2'd1;
    rr_order[3] = 2'd0; rr_order[4] = 2'd3;

    // 1: reset with all requests high
    rst_n = 1'b0;
    if_fix.req = 4'b1111;
    if_rr.req  = 4'b1111;
    if_ph.req  = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_grant("reset_fix", if_fix.gnt, if_fix.gnt_id, if_fix.gnt_valid, if_fix.preempt, 4'b0000, 2'd0, 1'b0);
      chk_grant("reset_rr",  if_rr.gnt,  if_rr.gnt_id,  if_rr.gnt_valid,  if_rr.preempt,  4'b0000, 2'd0, 1'b0);
      chk_grant("reset_ph",  if_ph.gnt,  if_ph.gnt_id,  if_ph.gnt_valid,  if_ph.preempt,  4'b0000, 2'd0, 1'b0);
    end

    // 2: fixed priority vector table
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if_fix.req = vecs[i].req;
      tick();
      chk_grant($sformatf("fix_vec%0d", i), if_fix.gnt, if_fix.gnt_id, if_fix.gnt_valid,
                if_fix.preempt, vecs[i].gnt, vecs[i].id, 1'b0);
    end

    // 3: round-robin, owner pulses its request low at each grant end
    do_reset();
    if_rr.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      cur = rr_order[k];
      chk_grant($sformatf("rr_grant%0d", k), if_rr.gnt, if_rr.gnt_id, if_rr.gnt_valid,
                if_rr.preempt, id_to_onehot(cur), cur, 1'b0);
      if (k < 4) begin
        if_rr.req = 4'b1111 & ~id_to_onehot(cur);
        tick();
        chk_grant($sformatf("rr_gap%0d", k), if_rr.gnt, if_rr.gnt_id, if_rr.gnt_valid,
                  if_rr.preempt, 4'b0000, 2'd0, 1'b0);
        if_rr.req = 4'b1111;
        tick();
      end
    end

    // 4: preemption after 4 grant cycles, preempted requester masked in gap
    do_reset();
    if_ph.req = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_grant($sformatf("pre_hold%0d", c), if_ph.gnt, if_ph.gnt_id, if_ph.gnt_valid,
                if_ph.preempt, 4'b1000, 2'd3, 1'b0);
    end
    tick();
    chk_grant("pre_gap", if_ph.gnt, if_ph.gnt_id, if_ph.gnt_valid, if_ph.preempt, 4'b0000, 2'd0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_grant($sformatf("pre_next%0d", c), if_ph.gnt, if_ph.gnt_id, if_ph.gnt_valid,
                if_ph.preempt, 4'b0001, 2'd0, 1'b0);
    end
    tick();
    chk_grant("pre_gap2", if_ph.gnt, if_ph.gnt_id, if_ph.gnt_valid, if_ph.preempt, 4'b0000, 2'd0, 1'b1);
    tick();
    chk_grant("pre_back", if_ph.gnt, if_ph.gnt_id, if_ph.gnt_valid, if_ph.preempt, 4'b1000, 2'd3, 1'b0);

    // release coincident with timeout counts as release
    for (int c = 0; c < 3; c++) tick();
    if_ph.req = 4'b0001;
    tick();
    chk_grant("rel_at_timeout", if_ph.gnt, if_ph.gnt_id, if_ph.gnt_valid, if_ph.preempt, 4'b0000, 2'd0, 1'b0);
    tick();
    chk_grant("rel_next", if_ph.gnt, if_ph.gnt_id, if_ph.gnt_valid, if_ph.preempt, 4'b0001, 2'd0, 1'b0);

    // 5: lone holder keeps the grant past MAX_HOLD
    do_reset();
    if_ph.req = 4'b0010;
    tick();
    for (int c = 0; c < 20; c++) begin
      chk_grant($sformatf("lone%0d", c), if_ph.gnt, if_ph.gnt_id, if_ph.gnt_valid,
                if_ph.preempt, 4'b0010, 2'd1, 1'b0);
      tick();
    end

    // 6: reset mid-grant
    do_reset();
    if_fix.req = 4'b0100;
    tick();
    chk_grant("mid_pre", if_fix.gnt, if_fix.gnt_id, if_fix.gnt_valid, if_fix.preempt, 4'b0100, 2'd2, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_grant("mid_rst", if_fix.gnt, if_fix.gnt_id, if_fix.gnt_valid, if_fix.preempt, 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_grant("mid_after", if_fix.gnt, if_fix.gnt_id, if_fix.gnt_valid, if_fix.preempt, 4'b0100, 2'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
